// File: rtl/char_match_pkg.sv
// Shared types and defaults for the character stream matcher.
//   char_t          : one 8-bit stream character
//   MAXLEN_DEFAULT  : default maximum pattern length
//   CNTW_DEFAULT    : default width of the position and match counters
//   idx_t / len_t   : pattern slot index / pattern length at the default size
package char_match_pkg;
    localparam int MAXLEN_DEFAULT = 8;
    localparam int CNTW_DEFAULT   = 16;

    typedef logic [7:0] char_t;
    typedef logic [$clog2(MAXLEN_DEFAULT)-1:0]   idx_t;
    typedef logic [$clog2(MAXLEN_DEFAULT+1)-1:0] len_t;
endpackage

// File: rtl/char_stream_matcher_if.sv
// Bus bundle of the character stream matcher.
//   i_valid/i_ready/i_char          : character input handshake
//   cfg_we/cfg_idx/cfg_char/cfg_len : pattern programming port
//   o_valid/o_ready/o_pos           : match event handshake
//   o_count                         : saturating match count
// master = stream/config source and event sink, slave = the matcher.
interface char_stream_matcher_if #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 16
);
    import char_match_pkg::*;

    localparam int IW = $clog2(MAXLEN);
    localparam int LW = $clog2(MAXLEN + 1);

    logic            i_valid;
    logic            i_ready;
    char_t           i_char;
    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    char_t           cfg_char;
    logic [LW-1:0]   cfg_len;
    logic            o_valid;
    logic            o_ready;
    logic [CNTW-1:0] o_pos;
    logic [CNTW-1:0] o_count;

    modport master (
        output i_valid, i_char, cfg_we, cfg_idx, cfg_char, cfg_len, o_ready,
        input  i_ready, o_valid, o_pos, o_count
    );

    modport slave (
        input  i_valid, i_char, cfg_we, cfg_idx, cfg_char, cfg_len, o_ready,
        output i_ready, o_valid, o_pos, o_count
    );
endinterface

// File: rtl/char_match_window.sv
// Sliding window of the most recent characters plus its fill count.
//   clk, rst : clock, async active-low reset
//   accept   : shift din into slot 0 this cycle
//   clear    : forget window contents (fill back to 0)
//   din      : incoming character
//   win_nxt  : window as it will be after this cycle (slot 0 = newest)
//   fill     : number of valid characters currently held (pre-shift)
module char_match_window
    import char_match_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             accept,
    input  logic                             clear,
    input  char_t                            din,
    output char_t [MAXLEN-1:0]               win_nxt,
    output logic  [$clog2(MAXLEN+1)-1:0]     fill
);
    localparam int FW = $clog2(MAXLEN + 1);

    char_t [MAXLEN-1:0] win;

    // Exposed combinationally so the comparator sees the character
    // being accepted in the same cycle.
    always_comb begin
        win_nxt = win;
        if (accept) win_nxt = {win[MAXLEN-2:0], din};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win  <= '0;
            fill <= '0;
        end else begin
            win <= win_nxt;
            if (clear)
                fill <= '0;
            else if (accept && fill != FW'(MAXLEN))
                fill <= fill + 1'b1;
        end
    end
endmodule

// File: rtl/char_stream_matcher.sv
// Streaming substring detector with overlapping-match reporting.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of char_stream_matcher_if (input stream,
//              pattern config, match event output, match count)
// A match is checked on every accepted character against the last
// len characters; the event is registered one cycle later.
module char_stream_matcher
    import char_match_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEFAULT,
    parameter int CNTW   = CNTW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    char_stream_matcher_if.slave  bus
);
    localparam int IW = $clog2(MAXLEN);
    localparam int LW = $clog2(MAXLEN + 1);

    char_t [MAXLEN-1:0] pat;
    char_t [MAXLEN-1:0] win_nxt;
    logic  [LW-1:0]     len;
    logic  [LW-1:0]     fill;
    logic  [CNTW-1:0]   pos;
    logic  [MAXLEN-1:0] lane_ok;
    logic               accept, enabled, fill_ok, hit;

    // A stalled event blocks the stream so no match can be lost.
    assign bus.i_ready = !bus.cfg_we && (!bus.o_valid || bus.o_ready);
    assign accept      = bus.i_valid && bus.i_ready;

    char_match_window #(.MAXLEN(MAXLEN)) u_win (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .clear   (bus.cfg_we),
        .din     (bus.i_char),
        .win_nxt (win_nxt),
        .fill    (fill)
    );

    // Window slot k (k=0 newest) lines up with pattern slot len-1-k.
    // Slots at or beyond len are don't-care.
    for (genvar k = 0; k < MAXLEN; k++) begin : g_lane
        logic [IW-1:0] pidx;
        assign pidx       = IW'(len - LW'(k + 1));
        assign lane_ok[k] = (LW'(k) >= len) || (win_nxt[k] == pat[pidx]);
    end

    assign enabled = (len != '0) && (len <= LW'(MAXLEN));
    assign fill_ok = ({1'b0, fill} + 1'b1) >= {1'b0, len};
    assign hit     = accept && enabled && fill_ok && (&lane_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat         <= '0;
            len         <= '0;
            pos         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_pos   <= '0;
            bus.o_count <= '0;
        end else begin
            if (bus.cfg_we) begin
                pat[bus.cfg_idx] <= bus.cfg_char;
                len              <= bus.cfg_len;
            end
            if (accept) pos <= pos + 1'b1;
            // A new match overrides the handshake so back-to-back
            // events stay valid with the newer position.
            if (hit) begin
                bus.o_valid <= 1'b1;
                bus.o_pos   <= pos;
                if (bus.o_count != '1) bus.o_count <= bus.o_count + 1'b1;
            end else if (bus.o_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_char_stream_matcher.sv
module tb_char_stream_matcher;
    import char_match_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    char_stream_matcher_if #(.MAXLEN(8), .CNTW(16)) bus ();

    char_stream_matcher #(.MAXLEN(8), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pattern as a string-like array, history of
    // characters accepted since the last config write / reset.
    byte m_pat [8];
    int  m_len;
    byte hist [$];
    int  m_pos;
    bit  exp_valid;
    int  exp_pos;
    int  exp_count;
    bit  exp_rdy;
    bit  obs_rdy;
    bit  prev_vld;
    int  obs_q [$];

    function automatic bit model_match();
        if (m_len < 1 || m_len > 8 || hist.size() < m_len) return 1'b0;
        for (int j = 0; j < m_len; j++)
            if (hist[hist.size() - m_len + j] != m_pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        foreach (m_pat[i]) m_pat[i] = 8'h00;
        m_len = 0; hist.delete(); m_pos = 0;
        exp_valid = 0; exp_pos = 0; exp_count = 0;
        prev_vld = 0; obs_q.delete();
    endtask

    // Record each distinct event seen at the output.
    task automatic observe(input bit ordy);
        if (bus.o_valid && (!prev_vld || ordy)) obs_q.push_back(int'(bus.o_pos));
        prev_vld = bus.o_valid;
    endtask

    // One clock: drive at negedge, return at next negedge.
    task automatic step(input bit iv, input byte ch, input bit ordy);
        bit acc, h;
        int mp;
        bus.cfg_we = 0; bus.i_valid = iv; bus.i_char = ch; bus.o_ready = ordy;
        #1;
        obs_rdy = bus.i_ready;
        exp_rdy = !exp_valid || ordy;
        acc = iv && exp_rdy;
        h = 0; mp = 0;
        if (acc) begin
            hist.push_back(ch);
            if (hist.size() > 8) void'(hist.pop_front());
            h = model_match();
            mp = m_pos;
            m_pos = (m_pos + 1) % 65536;
        end
        if (h) begin
            exp_valid = 1; exp_pos = mp;
            if (exp_count < 65535) exp_count++;
        end else if (ordy) exp_valid = 0;
        @(negedge clk);
        observe(ordy);
        bus.i_valid = 0;
    endtask

    task automatic cfg_write(input int idx, input byte ch, input int len, input bit iv);
        bus.cfg_we = 1; bus.cfg_idx = 3'(idx); bus.cfg_char = ch; bus.cfg_len = 4'(len);
        bus.i_valid = iv; bus.i_char = 8'h41; bus.o_ready = 1;
        #1;
        obs_rdy = bus.i_ready;
        m_pat[idx] = ch; m_len = len; hist.delete();
        exp_valid = 0;
        @(negedge clk);
        observe(1'b1);
        bus.cfg_we = 0; bus.i_valid = 0;
    endtask

    task automatic program_pattern(input string s);
        if (s.len() == 0) cfg_write(0, 8'h00, 0, 0);
        for (int i = 0; i < s.len(); i++) cfg_write(i, s[i], s.len(), 0);
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        #10 rst = 1;
    endtask

    task automatic test_reset();
        bus.i_valid = 0; bus.cfg_we = 0; bus.o_ready = 1;
        bus.i_char = 0; bus.cfg_idx = 0; bus.cfg_char = 0; bus.cfg_len = 0;
        model_reset();
        #1;
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %0d want 0", bus.o_valid); else n_pass++;
        n_checks++; if (bus.o_pos !== 16'd0) $display("FAIL reset_o_pos: got %0d want 0", bus.o_pos); else n_pass++;
        n_checks++; if (bus.o_count !== 16'd0) $display("FAIL reset_o_count: got %0d want 0", bus.o_count); else n_pass++;
        n_checks++; if (bus.i_ready !== 1'b1) $display("FAIL reset_i_ready: got %0d want 1", bus.i_ready); else n_pass++;
    endtask

    task automatic run_fixed(input string p, input string s, input int e0, input int e1, input int ne);
        do_reset();
        program_pattern(p);
        for (int i = 0; i < s.len(); i++) begin
            step(1, s[i], 1);
            n_checks++; if (bus.o_valid !== exp_valid) $display("FAIL %s_valid@%0d: got %0d want %0d", p, i, bus.o_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_checks++; if (int'(bus.o_pos) != exp_pos) $display("FAIL %s_pos@%0d: got %0d want %0d", p, i, bus.o_pos, exp_pos); else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != ne) $display("FAIL %s_events: got %0d want %0d", p, obs_q.size(), ne); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] != e0) $display("FAIL %s_ev0: got %0d want %0d", p, obs_q[0], e0); else n_pass++;
        end
        if (ne > 1 && obs_q.size() > 1) begin
            n_checks++; if (obs_q[1] != e1) $display("FAIL %s_ev1: got %0d want %0d", p, obs_q[1], e1); else n_pass++;
        end
        n_checks++; if (int'(bus.o_count) != ne) $display("FAIL %s_count: got %0d want %0d", p, bus.o_count, ne); else n_pass++;
    endtask

    task automatic test_patterns();
        run_fixed("ABA",    "AABABA__JUSTMONIKA__CDEDE", 3, 5, 2);
        run_fixed("MONIKA", "AABABA__JUSTMONIKA__CDEDE", 17, 0, 1);
        run_fixed("DE",     "AABABA__JUSTMONIKA__CDEDE", 22, 24, 2);
        run_fixed("AA",     "AAAA", 1, 2, 3);
    endtask

    task automatic test_stall();
        do_reset();
        program_pattern("ABA");
        step(1, "A", 1); step(1, "B", 1); step(1, "A", 1);
        n_checks++; if (bus.o_valid !== 1'b1 || bus.o_pos !== 16'd2) $display("FAIL stall_first: got v=%0d pos=%0d want v=1 pos=2", bus.o_valid, bus.o_pos); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1, "B", 0);
            n_checks++; if (obs_rdy !== 1'b0) $display("FAIL stall_i_ready: got %0d want 0", obs_rdy); else n_pass++;
            n_checks++; if (bus.o_valid !== 1'b1 || bus.o_pos !== 16'd2 || bus.o_count !== 16'd1) $display("FAIL stall_hold: got v=%0d pos=%0d cnt=%0d want 1/2/1", bus.o_valid, bus.o_pos, bus.o_count); else n_pass++;
        end
        step(1, "B", 1);
        step(1, "A", 1);
        n_checks++; if (bus.o_valid !== 1'b1 || bus.o_pos !== 16'd4) $display("FAIL stall_second: got v=%0d pos=%0d want v=1 pos=4", bus.o_valid, bus.o_pos); else n_pass++;
        n_checks++; if (bus.o_count !== 16'd2) $display("FAIL stall_count: got %0d want 2", bus.o_count); else n_pass++;
        n_checks++; if (obs_q.size() != 2) $display("FAIL stall_events: got %0d want 2", obs_q.size()); else n_pass++;
    endtask

    task automatic test_len0();
        do_reset();
        program_pattern("");
        for (int i = 0; i < 20; i++) begin
            step(1, byte'($urandom_range(65, 66)), 1'($urandom_range(0, 1)));
            n_checks++; if (bus.o_valid !== 1'b0 || bus.o_count !== 16'd0) $display("FAIL len0@%0d: got v=%0d cnt=%0d want 0/0", i, bus.o_valid, bus.o_count); else n_pass++;
        end
        step(1, "A", 1); step(1, "A", 1); step(1, "A", 1);
        // config write with i_valid high: the write wins
        cfg_write(0, "A", 3, 1);
        n_checks++; if (obs_rdy !== 1'b0) $display("FAIL cfg_blocks_input: got %0d want 0", obs_rdy); else n_pass++;
        cfg_write(1, "A", 3, 1);
        cfg_write(2, "A", 3, 0);
        step(1, "A", 1); step(1, "A", 1);
        n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL len3_early: got %0d want 0", bus.o_valid); else n_pass++;
        step(1, "A", 1);
        n_checks++; if (bus.o_valid !== 1'b1 || int'(bus.o_pos) != exp_pos) $display("FAIL len3_match: got v=%0d pos=%0d want v=1 pos=%0d", bus.o_valid, bus.o_pos, exp_pos); else n_pass++;
        n_checks++; if (exp_pos != 25) $display("FAIL len3_pos_model: got %0d want 25", exp_pos); else n_pass++;
        n_checks++; if (bus.o_count !== 16'd1) $display("FAIL len3_count: got %0d want 1", bus.o_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        program_pattern("AB");
        for (int i = 0; i < 6; i++) step(1, (i % 2) ? "B" : "A", 1);
        rst = 0;
        model_reset();
        #1;
        n_checks++; if (bus.o_valid !== 1'b0 || bus.o_count !== 16'd0) $display("FAIL mid_reset: got v=%0d cnt=%0d want 0/0", bus.o_valid, bus.o_count); else n_pass++;
        #9 rst = 1;
        program_pattern("Q");
        step(1, "Q", 1);
        n_checks++; if (bus.o_valid !== 1'b1 || bus.o_pos !== 16'd0) $display("FAIL after_reset_pos: got v=%0d pos=%0d want v=1 pos=0", bus.o_valid, bus.o_pos); else n_pass++;
    endtask

    task automatic test_random();
        string p;
        int    plen;
        do_reset();
        plen = $urandom_range(1, 4);
        p = "";
        for (int i = 0; i < plen; i++) p = {p, ($urandom_range(0, 1) != 0) ? "A" : "B"};
        program_pattern(p);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), byte'($urandom_range(65, 66)), 1'($urandom_range(0, 9) < 7));
            n_checks++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_ready@%0d: got %0d want %0d", i, obs_rdy, exp_rdy); else n_pass++;
            n_checks++; if (bus.o_valid !== exp_valid) $display("FAIL rnd_valid@%0d: got %0d want %0d", i, bus.o_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_checks++; if (int'(bus.o_pos) != exp_pos) $display("FAIL rnd_pos@%0d: got %0d want %0d", i, bus.o_pos, exp_pos); else n_pass++;
            end
            n_checks++; if (int'(bus.o_count) != exp_count) $display("FAIL rnd_count@%0d: got %0d want %0d", i, bus.o_count, exp_count); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        rst = 1;
        test_patterns();
        test_stall();
        test_len0();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
